// File: rtl/regfile_scb.sv
// regfile_scb: multi-port register file with write bypass, load scoreboard and bulk-clear engine.
// Define RF_ZERO_REG_EN to hardwire register 0 to zero.
module regfile_scb #(
    parameter int WIDTH        = 16,
    parameter int REGNUM       = 16,
    parameter int ADDRESSWIDTH = 4,
    parameter int NREAD        = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NREAD*ADDRESSWIDTH-1:0]  ra,
    output logic [NREAD*WIDTH-1:0]         rd,
    output logic [NREAD-1:0]               busy,
    input  logic [WIDTH-1:0]               r15,
    input  logic                           we_a,
    input  logic [ADDRESSWIDTH-1:0]        wa_a,
    input  logic [WIDTH-1:0]               wd_a,
    input  logic                           we_b,
    input  logic [ADDRESSWIDTH-1:0]        wa_b,
    input  logic [WIDTH-1:0]               wd_b,
    input  logic                           rsv,
    input  logic [ADDRESSWIDTH-1:0]        rsv_addr,
    input  logic                           clr_req,
    output logic                           clr_busy,
    output logic                           clr_done
);
`ifdef RF_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CLEAR = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [WIDTH-1:0]        regs [REGNUM];
    logic [REGNUM-1:0]       pend;
    logic [1:0]              state;
    logic [ADDRESSWIDTH-1:0] cnt;
    logic                    wen_a, wen_b, rsv_en, last;

    // Only plain architectural registers accept writes and reservations.
    function automatic logic writable(input logic [ADDRESSWIDTH-1:0] a);
        return 32'(a) < REGNUM - 1 && !(ZERO_REG && a == '0);
    endfunction

    assign wen_a    = we_a && state != CLEAR && writable(wa_a);
    assign wen_b    = we_b && state != CLEAR && writable(wa_b);
    assign rsv_en   = rsv && state != CLEAR && writable(rsv_addr);
    assign last     = 32'(cnt) == REGNUM - 2;
    assign clr_busy = state == CLEAR;
    assign clr_done = state == DONE;

    for (genvar i = 0; i < NREAD; i++) begin : g_rd
        logic [ADDRESSWIDTH-1:0] a;
        assign a = ra[i*ADDRESSWIDTH +: ADDRESSWIDTH];
        assign rd[i*WIDTH +: WIDTH] = 32'(a) == REGNUM - 1 ? r15 :
                                      (32'(a) >= REGNUM || (ZERO_REG && a == '0)) ? '0 :
                                      (wen_b && wa_b == a) ? wd_b :
                                      (wen_a && wa_a == a) ? wd_a : regs[a];
        assign busy[i] = writable(a) && pend[a] && !(wen_b && wa_b == a);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            pend  <= '0;
            for (int k = 0; k < REGNUM; k++) regs[k] <= '0;
        end else begin
            state <= state == IDLE ? (clr_req ? CLEAR : IDLE) :
                     state == CLEAR ? (last ? DONE : CLEAR) : IDLE;
            cnt   <= state == CLEAR ? cnt + ADDRESSWIDTH'(1) : '0;
            if (state == CLEAR) begin
                regs[cnt] <= '0;
                pend[cnt] <= 1'b0;
            end else begin
                if (wen_a) regs[wa_a] <= wd_a;
                if (wen_b) regs[wa_b] <= wd_b;
                if (wen_b) pend[wa_b] <= 1'b0;
                // A fresh reservation outranks a retiring load to the same register.
                if (rsv_en) pend[rsv_addr] <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_regfile_scb.sv
// tb_regfile_scb: scoreboard-driven bench for regfile_scb.
module tb_regfile_scb;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  ra;
    logic [31:0] rd;
    logic [1:0]  busy;
    logic [15:0] r15, wd_a, wd_b;
    logic [3:0]  wa_a, wa_b, rsv_addr;
    logic        we_a, we_b, rsv, clr_req, clr_busy, clr_done;
    int          n_chk = 0, n_pass = 0;
    string       tag_q[$];
    logic [31:0] exp_q[$];

    regfile_scb dut (
        .clk(clk), .rst_n(rst_n), .ra(ra), .rd(rd), .busy(busy), .r15(r15),
        .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a), .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b),
        .rsv(rsv), .rsv_addr(rsv_addr), .clr_req(clr_req),
        .clr_busy(clr_busy), .clr_done(clr_done)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", tag, got, exp);
    endtask

    task automatic want(string tag, logic [31:0] v);
        tag_q.push_back(tag);
        exp_q.push_back(v);
    endtask

    task automatic got(logic [31:0] v);
        if (exp_q.size() == 0) begin
            n_chk++;
            $display("FAIL scoreboard_empty: got %h want none", v);
        end else check(tag_q.pop_front(), v, exp_q.pop_front());
    endtask

    task automatic idle();
        we_a = 0; we_b = 0; rsv = 0; clr_req = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        int nb, nd, done_at, last_busy;
        idle();
        rst_n = 0; r15 = 16'h0108; ra = {4'd15, 4'd0};
        wa_a = 0; wa_b = 0; wd_a = 0; wd_b = 0; rsv_addr = 0;
        #12;
        for (int i = 0; i < 15; i++) begin
            ra[3:0] = 4'(i);
            #1;
            want($sformatf("reset_rd%0d", i), 0); got({16'h0, rd[15:0]});
        end
        want("reset_r15", 16'h0108); got({16'h0, rd[31:16]});
        want("reset_busy", 0);       got({30'h0, busy});
        want("reset_clr", 0);        got({30'h0, clr_busy, clr_done});
        @(negedge clk) rst_n = 1;

        @(negedge clk) ra = {4'd15, 4'd3}; we_a = 1; wa_a = 3; wd_a = 16'hBEEF;
        #1 want("bypass_a", 16'hBEEF); got({16'h0, rd[15:0]});
        @(negedge clk) we_a = 0;
        #1 want("stored_a", 16'hBEEF); got({16'h0, rd[15:0]});
        @(negedge clk) ra[3:0] = 15; we_a = 1; wa_a = 15; wd_a = 16'h1234;
        #1 want("pc_alias_bypass", 16'h0108); got({16'h0, rd[15:0]});
        @(negedge clk) we_a = 0;
        #1 want("pc_alias_write", 16'h0108); got({16'h0, rd[15:0]});

        @(negedge clk) ra[3:0] = 5; we_a = 1; wa_a = 5; wd_a = 16'h1111; we_b = 1; wa_b = 5; wd_b = 16'h2222;
        #1 want("b_wins_bypass", 16'h2222); got({16'h0, rd[15:0]});
        @(negedge clk) idle();
        #1 want("b_wins_stored", 16'h2222); got({16'h0, rd[15:0]});

        @(negedge clk) ra[7:4] = 7; rsv = 1; rsv_addr = 7;
        #1 want("rsv_same_cycle", 0); got({31'h0, busy[1]});
        @(negedge clk) rsv = 0;
        #1 want("rsv_busy", 1); got({31'h0, busy[1]});
        @(negedge clk) we_b = 1; wa_b = 7; wd_b = 16'h00AA;
        #1 want("retire_mask", 0); got({31'h0, busy[1]});
        want("retire_rd", 16'h00AA); got({16'h0, rd[31:16]});
        @(negedge clk) we_b = 0;
        #1 want("retired_busy", 0); got({31'h0, busy[1]});
        @(negedge clk) rsv = 1; we_b = 1; wd_b = 16'h0055;
        #1 want("rsv_retire_mask", 0); got({31'h0, busy[1]});
        @(negedge clk) idle();
        #1 want("rsv_wins", 1); got({31'h0, busy[1]});
        want("rsv_wins_rd", 16'h0055); got({16'h0, rd[31:16]});
        @(negedge clk) we_a = 1; wa_a = 7; wd_a = 16'h3333;
        #1 want("a_no_mask", 1); got({31'h0, busy[1]});
        want("a_bypass_pend", 16'h3333); got({16'h0, rd[31:16]});
        @(negedge clk) idle();
        #1 want("a_keeps_pend", 1); got({31'h0, busy[1]});

        for (int i = 0; i < 15; i++) begin
            @(negedge clk) we_a = 1; wa_a = 4'(i); wd_a = 16'(i * 16'h1111 + 1);
        end
        @(negedge clk) we_a = 0; rsv = 1; rsv_addr = 9;
        @(negedge clk) rsv = 0; clr_req = 1;
        nb = 0; nd = 0; done_at = -1; last_busy = -1;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk) idle();
            #1;
            if (clr_busy) begin nb++; last_busy = c; end
            if (clr_done) begin nd++; done_at = c; end
            if (clr_busy && nb == 10) begin
                we_a = 1; wa_a = 3; wd_a = 16'hDEAD; rsv = 1; rsv_addr = 2;
            end
        end
        want("clr_busy_cycles", 15); got(nb);
        want("clr_done_pulses", 1);  got(nd);
        want("clr_done_after", last_busy + 1); got(done_at);
        want("clr_idle", 0); got({31'h0, clr_busy});
        for (int i = 0; i < 15; i++) begin
            ra = {4'(i), 4'(i)};
            #1;
            want($sformatf("cleared_rd%0d", i), 0);   got({16'h0, rd[15:0]});
            want($sformatf("cleared_busy%0d", i), 0); got({31'h0, busy[1]});
        end

        @(negedge clk) ra = {4'd15, 4'd12}; we_a = 1; wa_a = 12; wd_a = 16'hC0DE; rsv = 1; rsv_addr = 12;
        @(negedge clk) idle();
        #1 want("pre_abort_rd", 16'hC0DE); got({16'h0, rd[15:0]});
        want("pre_abort_busy", 1); got({31'h0, busy[0]});
        clr_req = 1;
        nb = 0;
        for (int c = 0; c < 10 && nb < 4; c++) begin
            @(negedge clk) clr_req = 0;
            #1 if (clr_busy) nb++;
        end
        want("abort_point", 4); got(nb);
        rst_n = 0;
        #1 want("abort_clr_busy", 0); got({31'h0, clr_busy});
        want("abort_rd", 0);    got({16'h0, rd[15:0]});
        want("abort_busy", 0);  got({30'h0, busy});
        want("abort_r15", 16'h0108); got({16'h0, rd[31:16]});
        @(negedge clk) rst_n = 1;
        @(negedge clk) #1 want("abort_idle", 0); got({31'h0, clr_busy});

        @(negedge clk) ra[3:0] = 0; we_a = 1; wa_a = 0; wd_a = 16'hFFFF;
`ifdef RF_ZERO_REG_EN
        #1 want("zero_bypass", 0); got({16'h0, rd[15:0]});
        @(negedge clk) idle();
        #1 want("zero_stored", 0); got({16'h0, rd[15:0]});
`else
        #1 want("r0_bypass", 16'hFFFF); got({16'h0, rd[15:0]});
        @(negedge clk) idle();
        #1 want("r0_stored", 16'hFFFF); got({16'h0, rd[15:0]});
`endif
        if (exp_q.size() != 0) begin
            n_chk++;
            $display("FAIL scoreboard_left: got %0d want 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/regfile_scb.md
Name: regfile_scb

Overview:
Parametrised successor to the core register file. Provides NREAD combinational read ports and two write ports: A for ALU writeback, B for memory/load writeback. Adds same-cycle write-to-read bypass, a pending-load scoreboard for hazard stalls, and a sequenced bulk-clear engine. Sits in the decode/writeback stages of the pipelined datapath, feeding operand muxes and the hazard unit.

Parameters:
WIDTH, 16, data width of each register
REGNUM, 16, number of architectural registers; index REGNUM-1 is the PC alias
ADDRESSWIDTH, 4, register index width; must satisfy 2**ADDRESSWIDTH >= REGNUM
NREAD, 2, number of read ports (1..4)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
ra  in  NREAD*ADDRESSWIDTH  read addresses; port i occupies slice [i*ADDRESSWIDTH +: ADDRESSWIDTH]
rd  out  NREAD*WIDTH  read data, packed the same way
busy  out  NREAD  per-port scoreboard hit: operand not yet valid
r15  in  WIDTH  PC+8 value returned for index REGNUM-1
we_a, wa_a, wd_a  in  1/ADDRESSWIDTH/WIDTH  write port A
we_b, wa_b, wd_b  in  1/ADDRESSWIDTH/WIDTH  write port B; also retires pending loads
rsv  in  1  mark register rsv_addr pending
rsv_addr  in  ADDRESSWIDTH  register to reserve
clr_req  in  1  start bulk clear (level sampled in IDLE)
clr_busy  out  1  high while the clear engine runs
clr_done  out  1  one-cycle pulse when the clear completes

Behaviour:
- Reset (rst_n=0, async): all registers 0, all pending bits 0, FSM=IDLE, clr_busy=0, clr_done=0. rd and busy then follow combinationally: 0 for normal indices, r15 for index REGNUM-1.
- Read, combinational, zero latency; evaluated per port i, highest priority first:
  - index REGNUM-1 -> r15;
  - index >= REGNUM -> 0;
  - we_b && wa_b==ra_i -> wd_b (bypass);
  - we_a && wa_a==ra_i -> wd_a (bypass);
  - otherwise the stored value.
- Write, at rising edge: we_a writes wd_a to wa_a; we_b writes wd_b to wa_b. If both target the same address, B wins. Writes to REGNUM-1 or to indices >= REGNUM are ignored.
- Scoreboard: one pend bit per register.
  - rsv sets pend[rsv_addr] at the edge.
  - we_b clears pend[wa_b] at the edge.
  - If rsv and we_b hit the same address in the same cycle, the set wins: a new load is outstanding.
  - Port A writes do not touch pend.
  - busy[i] = pend[ra_i] && !(we_b && wa_b==ra_i). busy is never set for REGNUM-1.
- Clear FSM, states IDLE, CLEAR, DONE:
  - IDLE -> CLEAR when clr_req=1. The counter loads 0.
  - In CLEAR, each cycle writes 0 to reg[cnt] and clears pend[cnt], then cnt increments. After cnt reaches REGNUM-2, go to DONE. A full clear takes REGNUM-1 cycles.
  - DONE: clr_done=1 for one cycle, then IDLE. clr_req is ignored in DONE.
  - clr_busy=1 in CLEAR only.
  - While in CLEAR, both write ports and rsv are ignored. Reads still work, including bypass of the ignored writes: none occurs, so stored contents are returned.
  - rst_n low mid-clear aborts immediately to the reset state.
- Width rules: no arithmetic on data. The counter is ADDRESSWIDTH bits and never wraps, because it stops at REGNUM-2.

Optional Feature:
RF_ZERO_REG_EN:
- Defined: register 0 is hardwired to zero. Reads of index 0 return 0 and bypass is suppressed. Writes and reservations to 0 are discarded, and busy is never set for index 0.
- Undefined: register 0 is an ordinary register.

Test Plan:
- Reset then read all ports: rd=0 for indices 0..14, rd=r15 (e.g. 16'h0108) for index 15, busy=0, clr_busy=0.
- Write 16'hBEEF to reg 3 via A while ra0=3: rd0=16'hBEEF in the same cycle; next cycle read from storage = 16'hBEEF. Write to reg 15 is ignored.
- Same cycle we_a (reg 5, 16'h1111) and we_b (reg 5, 16'h2222): rd=16'h2222 combinationally and after the edge.
- rsv reg 7; next cycle ra1=7 -> busy[1]=1. Then we_b reg 7 = 16'h00AA -> busy[1]=0 in that cycle and rd1=16'h00AA. Same-cycle rsv+we_b on reg 7 leaves busy=1 afterwards.
- Fill regs with nonzero values and pend bits, pulse clr_req: clr_busy high 15 cycles, clr_done one pulse, all regs 0, pend 0. A we_a issued during CLEAR is lost.
- Assert rst_n low at clear cycle 4: outputs return to reset values asynchronously. With RF_ZERO_REG_EN, writing 16'hFFFF to reg 0 reads back 0.
